// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the EX stage and the iterative mul/div unit.
//
// Handshake: the unit samples start (with funct3/op1/op2) on a clock edge only
// while it is not busy. The stage must hold the pipeline while start|busy.
// After an accepted start, busy stays high until the result is ready. done is
// a one-cycle pulse in which result is valid. result then holds its value
// until the next completion. flush aborts any in-flight op without a done pulse.
interface ex_muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  modport master (
    output start, funct3, op1, op2, flush,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, funct3, op1, op2, flush,
    output busy, done, result, dbg_state
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 1-bit/cycle shift-add multiplier and
// restoring divider on operand magnitudes, with sign correction at the end.
// Divide-by-zero and signed overflow complete in one cycle without iterating.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg_res;   // final product/quotient must be negated
  logic              r_neg_rem;   // remainder takes the dividend sign
  logic [XLEN-1:0]   r_x;         // multiplier (shifts right) or dividend->quotient (shifts left)
  logic [XLEN-1:0]   r_y;         // divisor magnitude
  logic [2*XLEN-1:0] r_mcand;     // multiplicand, shifted left each step
  logic [2*XLEN-1:0] r_acc;       // product accumulator
  logic [XLEN-1:0]   r_rem;       // partial remainder

  // Operand decode on the start edge
  logic            w_is_div, w_s1, w_s2, w_neg1, w_neg2, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res;

  assign w_is_div   = bus.funct3[2];
  assign w_s1       = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_s2       = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_neg1     = w_s1 & bus.op1[XLEN-1];
  assign w_neg2     = w_s2 & bus.op2[XLEN-1];
  assign w_mag1     = w_neg1 ? -bus.op1 : bus.op1;
  assign w_mag2     = w_neg2 ? -bus.op2 : bus.op2;
  assign w_div0     = w_is_div & (bus.op2 == '0);
  assign w_ovf      = w_is_div & ~bus.funct3[0] & (bus.op1 == MIN_NEG) & (bus.op2 == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (bus.funct3[1] ? bus.op1 : '1)
                             : (bus.funct3[1] ? '0 : MIN_NEG);

  // One iteration step of both datapaths
  logic [2*XLEN-1:0] w_prod_next, w_prod_fix;
  logic [XLEN:0]     w_rem_shift, w_rem_sub;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_next, w_quo_next, w_quo_fix, w_rem_fix;

  assign w_prod_next = r_acc + (r_x[0] ? r_mcand : '0);
  assign w_rem_shift = {r_rem, r_x[XLEN-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_y};
  assign w_qbit      = ~w_rem_sub[XLEN];
  assign w_rem_next  = w_qbit ? w_rem_sub[XLEN-1:0] : w_rem_shift[XLEN-1:0];
  assign w_quo_next  = {r_x[XLEN-2:0], w_qbit};
  assign w_prod_fix  = r_neg_res ? -w_prod_next : w_prod_next;
  assign w_quo_fix   = r_neg_res ? -w_quo_next : w_quo_next;
  assign w_rem_fix   = r_neg_rem ? -w_rem_next : w_rem_next;

  // Select the completed result for the latched op
  logic [XLEN-1:0] w_calc_res;
  always_comb begin
    w_calc_res = '0;
    case (r_f3)
      3'b000:                 w_calc_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_calc_res = w_quo_fix;
      default:                w_calc_res = w_rem_fix;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (bus.start) begin
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_f3      <= bus.funct3;
              r_neg_res <= w_neg1 ^ w_neg2;
              r_neg_rem <= w_neg1;
              r_x       <= w_is_div ? w_mag1 : w_mag2;
              r_y       <= w_mag2;
              r_mcand   <= {{XLEN{1'b0}}, w_mag1};
              r_acc     <= '0;
              r_rem     <= '0;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_f3[2]) begin
            r_x   <= w_quo_next;
            r_rem <= w_rem_next;
          end else begin
            r_x     <= r_x >> 1;
            r_mcand <= r_mcand << 1;
            r_acc   <= w_prod_next;
          end
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_result <= w_calc_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.dbg_state = r_state;

endmodule
